fb_pixel_writer: RTL
====================

// Module: fb_pixel_writer
// PURPOSE
//   Avalon-MM write master that stores RGB555 pixels into the 800x600x16bpp DRAM
//   framebuffer scanned out by the display path; the write-side counterpart of
//   the scan-out read master. Takes (x,y,colour) over a valid/ready stream, merges
//   horizontally adjacent even/odd pixel pairs into one 32-bit word, queues the
//   words in a FIFO and issues byte-enabled single writes. Runs on sys clk.
// PARAMETERS
//   H_PIXELS      16'd800  visible width; also the row pitch in pixels (must be even)
//   V_PIXELS      16'd600  visible height
//   FIFO_DEPTH    8        write-command FIFO entries (power of 2, >=2)
//   FLUSH_CYCLES  16       idle cycles after which a pending partial word is flushed
// PORTS
//   clk               in   1   system clock
//   rst               in   1   async reset, active-high
//   start             in   1   pulse: latch fbAddr, clear drop_count (honoured only when busy=0)
//   fbAddr            in   32  framebuffer base byte address; bits [1:0] treated as 0
//   flush             in   1   pulse: push the pending word to the FIFO now
//   pix_valid         in   1   pixel offered
//   pix_ready         out  1   pixel accepted when pix_valid & pix_ready
//   pix_x             in   16  column
//   pix_y             in   16  row
//   pix_data          in   16  {1'bx, R[4:0], G[4:0], B[4:0]}; bit 15 written as-is
//   master_address    out  32  word-aligned byte address
//   master_write      out  1   write request
//   master_writedata  out  32  write data
//   master_byteenable out  4   byte lanes
//   master_wait_request in 1   slave stall
//   busy              out  1   pending word valid OR FIFO non-empty OR write in flight
//   drop_count        out  16  saturating count of discarded out-of-range pixels
// BEHAVIOUR
// - Reset: master_write=0, master_address=0, master_writedata=0, master_byteenable=0,
//   pix_ready=0, busy=0, drop_count=0, base=0, FIFO empty, pending invalid, idle ctr=0.
// - Address: idx = pix_y*H_PIXELS + pix_x (32-bit); word = base + {idx[31:1],2'b00};
//   x even -> data[15:0], be 4'b0011; x odd -> data[31:16], be 4'b1100.
// - pix_ready = !rst & !fifo_full & !flush (no accept in a flush cycle).
// - Out of range (x>=H_PIXELS or y>=V_PIXELS): accepted, discarded, drop_count+1
//   (saturates at 16'hFFFF); pending word and idle counter unaffected.
// - Coalesce FSM, states EMPTY / PEND:
//   EMPTY + accept       -> load pending {addr,data lane,be}; -> PEND.
//   PEND + accept, same word  -> merge lane, be |= new be (same lane: newer data wins).
//   PEND + accept, other word -> push pending to FIFO, load new pixel; stay PEND.
//   PEND + flush         -> push pending; -> EMPTY.
//   PEND + FLUSH_CYCLES consecutive cycles without accept -> push; -> EMPTY.
//   EMPTY + flush        -> no effect.
//   pix_ready low when FIFO full guarantees every push has space.
// - Write port: FIFO head registered onto master_*; master_write held with address,
//   data, byteenable stable while master_wait_request=1; entry retired on
//   master_write & !master_wait_request; next entry presented the following cycle
//   (back-to-back writes allowed). Writes leave in acceptance order.
// - Latency: accepted pixel completing a word (or flushed) -> master_write high
//   2 cycles later when FIFO was empty and no stall.
// - start while busy=1 is ignored; start and accept in same cycle: pixel uses new base.
// - Reset mid-transfer: abandons the FIFO and pending word immediately; no write
//   completes after rst rises.
// TESTING
//   1) start fbAddr=32'h1000_0000; pixels (0,0)=16'h7C00,(1,0)=16'h03E0, then idle
//      -> one write addr 32'h1000_0000 data 32'h03E0_7C00 be 4'hF.
//   2) single pixel (3,1)=16'h001F, flush -> addr base+32'h644 data 32'h001F_xxxx be 4'hC,
//      written exactly 2 cycles after the flush cycle.
//   3) pixels (800,0) and (0,600) -> no writes, drop_count=2, busy stays 0.
//   4) hold master_wait_request=1 for 50 cycles, stream 20 paired pixels -> pix_ready
//      drops after FIFO_DEPTH words + 1 pending; all 10 words written in order, none lost.
//   5) (10,5)=A, (10,5)=B, (11,5)=C -> one write data {C,B} be 4'hF.
//   6) assert rst with 4 words queued -> master_write low at once; after release no
//      stale write, pix_ready=1, drop_count=0.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: stream-to-framebuffer write master. Pixel pairs that share a
// 32-bit word are merged, queued in a small FIFO and written with byte enables.
module fb_pixel_writer #(
  parameter logic [15:0] H_PIXELS     = 16'd800,
  parameter logic [15:0] V_PIXELS     = 16'd600,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FLUSH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fbAddr,
  input  logic        flush,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic [15:0] pix_data,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  input  logic        master_wait_request,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FLUSH_CYCLES);

  typedef enum logic {EMPTY, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q;
  logic [31:0] pendAddr_q, pendAddr_d;
  logic [31:0] pendData_q, pendData_d;
  logic [3:0]  pendBe_q, pendBe_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0] dropCnt_q;

  logic [31:0] fifoAddr [FIFO_DEPTH];
  logic [31:0] fifoData [FIFO_DEPTH];
  logic [3:0]  fifoBe   [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   fifoCount_q;

  logic        mWrite_q;
  logic [31:0] mAddr_q, mData_q;
  logic [3:0]  mBe_q;

  logic        startOk, accept, inRange, fifoFull, fifoEmpty, pop, push;
  logic [31:0] baseEff, idx, pixAddr, pixData, mergedData;
  logic [3:0]  pixBe, mergedBe;
  logic [31:0] pushAddr, pushData;
  logic [3:0]  pushBe;

  assign fifoFull  = (fifoCount_q == (PW+1)'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCount_q == '0);
  assign busy      = (state_q == PEND) || !fifoEmpty || mWrite_q;
  assign pix_ready = !rst && !fifoFull && !flush;
  assign accept    = pix_valid && pix_ready;
  assign startOk   = start && !busy;
  assign baseEff   = startOk ? (fbAddr & 32'hFFFF_FFFC) : base_q;
  assign inRange   = (pix_x < H_PIXELS) && (pix_y < V_PIXELS);
  assign idx       = ({16'd0, pix_y} * {16'd0, H_PIXELS}) + {16'd0, pix_x};
  assign pixAddr   = baseEff + ((idx & 32'hFFFF_FFFE) << 1);
  assign pixBe     = pix_x[0] ? 4'b1100 : 4'b0011;
  assign pixData   = pix_x[0] ? {pix_data, 16'd0} : {16'd0, pix_data};
  assign mergedBe  = pendBe_q | pixBe;
  assign mergedData = pix_x[0] ? {pix_data, pendData_q[15:0]}
                               : {pendData_q[31:16], pix_data};
  assign pop       = !fifoEmpty && (!mWrite_q || !master_wait_request);

  // Coalescing decisions: load, merge, or push the pending word into the FIFO
  always_comb begin
    state_d    = state_q;
    pendAddr_d = pendAddr_q;
    pendData_d = pendData_q;
    pendBe_d   = pendBe_q;
    idle_d     = idle_q;
    push       = 1'b0;
    pushAddr   = pendAddr_q;
    pushData   = pendData_q;
    pushBe     = pendBe_q;
    case (state_q)
      EMPTY: begin
        if (accept && inRange) begin
          pendAddr_d = pixAddr;
          pendData_d = pixData;
          pendBe_d   = pixBe;
          idle_d     = '0;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (accept && inRange) begin
          idle_d = '0;
          if (pixAddr == pendAddr_q) begin
            if (mergedBe == 4'hF) begin
              push     = 1'b1;
              pushData = mergedData;
              pushBe   = mergedBe;
              state_d  = EMPTY;
            end else begin
              pendData_d = mergedData;
              pendBe_d   = mergedBe;
            end
          end else begin
            push       = 1'b1;
            pendAddr_d = pixAddr;
            pendData_d = pixData;
            pendBe_d   = pixBe;
          end
        end else if (!fifoFull && (flush || idle_q == IW'(FLUSH_CYCLES - 1))) begin
          push    = 1'b1;
          idle_d  = '0;
          state_d = EMPTY;
        end else if (!accept && idle_q != IW'(FLUSH_CYCLES - 1)) begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pending-word state, frame base and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      pendAddr_q <= '0;
      pendData_q <= '0;
      pendBe_q   <= '0;
      idle_q     <= '0;
      base_q     <= '0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pendAddr_q <= pendAddr_d;
      pendData_q <= pendData_d;
      pendBe_q   <= pendBe_d;
      idle_q     <= idle_d;
      base_q     <= baseEff;
      if (accept && !inRange) begin
        if (startOk) dropCnt_q <= 16'd1;
        else if (dropCnt_q != 16'hFFFF) dropCnt_q <= dropCnt_q + 16'd1;
      end else if (startOk) begin
        dropCnt_q <= '0;
      end
    end
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr_q] <= pushAddr;
      fifoData[wrPtr_q] <= pushData;
      fifoBe[wrPtr_q]   <= pushBe;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (push && !pop)      fifoCount_q <= fifoCount_q + 1'b1;
      else if (!push && pop) fifoCount_q <= fifoCount_q - 1'b1;
    end
  end

  // Avalon write stage: hold the request while stalled, reload on retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mWrite_q <= 1'b0;
      mAddr_q  <= '0;
      mData_q  <= '0;
      mBe_q    <= '0;
    end else if (pop) begin
      mWrite_q <= 1'b1;
      mAddr_q  <= fifoAddr[rdPtr_q];
      mData_q  <= fifoData[rdPtr_q];
      mBe_q    <= fifoBe[rdPtr_q];
    end else if (mWrite_q && !master_wait_request) begin
      mWrite_q <= 1'b0;
    end
  end

  assign master_write      = mWrite_q;
  assign master_address    = mAddr_q;
  assign master_writedata  = mData_q;
  assign master_byteenable = mBe_q;
  assign drop_count        = dropCnt_q;

endmodule
